// File: rtl/subservient_bus_pkg.sv
// Shared types and constants for the subservient peripheral bus.
// Holds the bus FSM states, the read data returned on errors and the reserved memory region.
package subservient_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } bus_state_e;

  localparam logic [31:0] ERR_RDT    = 32'h0;
  localparam int          MEM_REGION = 0;

endpackage

// File: rtl/subservient_bus_timeout.sv
// Saturating wait counter for slave acknowledges.
// Asserts expired once TIMEOUT-1 cycles have been counted since the last clear.
module subservient_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (a latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/subservient_periph_bus.sv
// Wishbone-style peripheral interconnect: decodes the top address bits to a slave,
// waits for its ack with a timeout, and reports unmapped or timed-out accesses as errors.
module subservient_periph_bus
  import subservient_bus_pkg::*;
#(
  parameter int NUM_SLAVES  = 3,
  parameter int REGION_BITS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_wb_adr,
  input  logic [31:0]              i_wb_dat,
  input  logic [3:0]               i_wb_sel,
  input  logic                     i_wb_we,
  input  logic                     i_wb_stb,
  output logic [31:0]              o_wb_rdt,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic [31:0]              o_s_adr,
  output logic [31:0]              o_s_dat,
  output logic [3:0]               o_s_sel,
  output logic                     o_s_we,
  output logic [NUM_SLAVES-1:0]    o_s_stb,
  input  logic [32*NUM_SLAVES-1:0] i_s_rdt,
  input  logic [NUM_SLAVES-1:0]    i_s_ack,
  output logic [31:0]              o_err_adr,
  output logic                     o_err_irq
);

  localparam int                     SEL_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [REGION_BITS-1:0] MEM_RGN  = REGION_BITS'(MEM_REGION);
  localparam logic [REGION_BITS-1:0] LAST_RGN = REGION_BITS'(NUM_SLAVES);

  bus_state_e             state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [31:0]            rdt_q, rdt_d;
  logic [31:0]            err_adr_q, err_adr_d;
  logic                   err_q, err_d;

  logic [REGION_BITS-1:0] region, region_idx;
  logic                   mapped;
  logic                   sel_ack;
  logic                   expired;
  logic [31:0]            slave_rdt [NUM_SLAVES];
  logic [31:0]            sel_rdt;

  assign o_s_adr = i_wb_adr;
  assign o_s_dat = i_wb_dat;
  assign o_s_sel = i_wb_sel;
  assign o_s_we  = i_wb_we;

  // Region 0 belongs to memory, so slave s answers to region s+1.
  assign region     = i_wb_adr[31 -: REGION_BITS];
  assign region_idx = region - REGION_BITS'(1);
  assign mapped     = (region != MEM_RGN) && (region <= LAST_RGN);

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_rdt
    assign slave_rdt[s] = i_s_rdt[32*s +: 32];
  end

  assign sel_rdt = slave_rdt[sel_q];
  assign sel_ack = i_s_ack[sel_q];

  subservient_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clear   (state_q != ACTIVE),
    .enable  ((state_q == ACTIVE) && !sel_ack),
    .expired (expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rdt_q     <= ERR_RDT;
      err_q     <= 1'b0;
      err_adr_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rdt_q     <= rdt_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rdt_d     = rdt_q;
    err_d     = err_q;
    err_adr_d = err_adr_q;
    unique case (state_q)
      IDLE: begin
        if (i_wb_stb) begin
          if (mapped) begin
            sel_d   = SEL_W'(region_idx);
            state_d = ACTIVE;
          end else begin
            state_d   = RESP;
            err_d     = 1'b1;
            rdt_d     = ERR_RDT;
            err_adr_d = i_wb_adr;
          end
        end
      end
      ACTIVE: begin
        // A dropped strobe aborts silently; an ack beats a timeout on the same cycle.
        if (!i_wb_stb) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdt_d   = sel_rdt;
        end else if (expired) begin
          state_d   = RESP;
          err_d     = 1'b1;
          rdt_d     = ERR_RDT;
          err_adr_d = i_wb_adr;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_s_stb = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      o_s_stb[s] = (state_q == ACTIVE) && (sel_q == SEL_W'(s));
    end
    o_wb_ack  = (state_q == RESP);
    o_wb_err  = o_wb_ack && err_q;
    o_err_irq = o_wb_ack && err_q;
  end

  assign o_wb_rdt  = rdt_q;
  assign o_err_adr = err_adr_q;

endmodule

// File: tb/tb_subservient_periph_bus.sv
// Directed bench for subservient_periph_bus: a vector table of complete transactions
// on a 3-slave/TIMEOUT=8 instance, plus hand sequences for abort, reset and a 2-slave instance.
module tb_subservient_periph_bus;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          ack_slave;
    int          waits;
    int          noise;
    logic [31:0] sdat;
    logic [2:0]  exp_stb;
    int          exp_cyc;
    int          exp_stbc;
    logic        exp_err;
    logic [31:0] exp_rdt;
    logic [31:0] exp_err_adr;
  } vec_t;

  typedef struct {
    int          ack_cyc;
    int          n_ack;
    int          n_irq;
    int          stbc;
    logic        err;
    logic [31:0] rdt;
    logic [31:0] err_adr;
    logic [2:0]  stb_or;
  } res_t;

  localparam int NV = 7;

  int checks   = 0;
  int failures = 0;

  logic        clk, rst;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, stb_a, stb_b;

  logic [31:0] rdt_a, s_adr_a, s_dat_a, err_adr_a;
  logic        ack_a, err_a, s_we_a, irq_a;
  logic [3:0]  s_sel_a;
  logic [2:0]  s_stb_a, s_ack_a;
  logic [95:0] s_rdt_a;

  logic [31:0] rdt_b, s_adr_b, s_dat_b, err_adr_b;
  logic        ack_b, err_b, s_we_b, irq_b;
  logic [3:0]  s_sel_b;
  logic [1:0]  s_stb_b, s_ack_b;
  logic [63:0] s_rdt_b;

  vec_t vecs [NV];
  vec_t fresh;

  subservient_periph_bus #(.NUM_SLAVES(3), .REGION_BITS(2), .TIMEOUT(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel), .i_wb_we(we),
    .i_wb_stb(stb_a), .o_wb_rdt(rdt_a), .o_wb_ack(ack_a), .o_wb_err(err_a),
    .o_s_adr(s_adr_a), .o_s_dat(s_dat_a), .o_s_sel(s_sel_a), .o_s_we(s_we_a), .o_s_stb(s_stb_a),
    .i_s_rdt(s_rdt_a), .i_s_ack(s_ack_a), .o_err_adr(err_adr_a), .o_err_irq(irq_a)
  );

  subservient_periph_bus #(.NUM_SLAVES(2), .REGION_BITS(2), .TIMEOUT(255)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel), .i_wb_we(we),
    .i_wb_stb(stb_b), .o_wb_rdt(rdt_b), .o_wb_ack(ack_b), .o_wb_err(err_b),
    .o_s_adr(s_adr_b), .o_s_dat(s_dat_b), .o_s_sel(s_sel_b), .o_s_we(s_we_b), .o_s_stb(s_stb_b),
    .i_s_rdt(s_rdt_b), .i_s_ack(s_ack_b), .o_err_adr(err_adr_b), .o_err_irq(irq_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one master transaction on dut_a; entered and left just after a rising edge.
  task automatic txn(input vec_t v, output res_t r);
    int  n_stb;
    bit  done;
    r.ack_cyc = -1; r.n_ack = 0; r.n_irq = 0; r.stbc = 0;
    r.err = 1'bx; r.rdt = 'x; r.err_adr = 'x; r.stb_or = '0;
    n_stb = 0;
    done  = 0;
    for (int s = 0; s < 3; s++) begin
      s_rdt_a[32*s +: 32] = (s == v.ack_slave) ? v.sdat : {16'hDEAD, 16'(s)};
    end
    adr = v.adr; we = v.we; dat = v.dat; sel = 4'hF; stb_a = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      s_ack_a = '0;
      if (s_stb_a != 3'b000) begin
        r.stb_or = r.stb_or | s_stb_a;
        r.stbc++;
        if (v.ack_slave >= 0 && n_stb == v.waits) s_ack_a[v.ack_slave] = 1'b1;
        if (v.noise >= 0 && n_stb == 0) s_ack_a[v.noise] = 1'b1;
        n_stb++;
      end
      @(negedge clk);
      if (irq_a) r.n_irq++;
      if (ack_a) begin
        r.n_ack++;
        r.ack_cyc = cyc;
        r.err     = err_a;
        r.rdt     = rdt_a;
        r.err_adr = err_adr_a;
        done      = 1;
      end
      @(posedge clk); #1;
    end
    stb_a = 1'b0; s_ack_a = '0;
    repeat (2) begin
      @(negedge clk);
      if (ack_a) r.n_ack++;
      if (irq_a) r.n_irq++;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    res_t r;
    txn(v, r);
    check({tag, " ack_cycle"}, r.ack_cyc, v.exp_cyc);
    check({tag, " ack_count"}, r.n_ack, 1);
    check({tag, " err"}, {31'h0, r.err}, {31'h0, v.exp_err});
    check({tag, " rdt"}, r.rdt, v.exp_rdt);
    check({tag, " err_adr"}, r.err_adr, v.exp_err_adr);
    check({tag, " irq_pulses"}, r.n_irq, {31'h0, v.exp_err});
    check({tag, " slave_stb"}, {29'h0, r.stb_or}, {29'h0, v.exp_stb});
    check({tag, " stb_cycles"}, r.stbc, v.exp_stbc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst = 1; stb_a = 0; stb_b = 0; adr = '0; dat = '0; sel = '0; we = 0;
    s_ack_a = '0; s_rdt_a = '0; s_ack_b = '0; s_rdt_b = '0;

    vecs[0] = '{32'h4000_0010, 1'b0, 32'h0,         0, 0, -1, 32'hA5A5_1234, 3'b001, 2, 1, 1'b0, 32'hA5A5_1234, 32'h0};
    vecs[1] = '{32'hC000_0004, 1'b1, 32'h1234_5678, 2, 5, -1, 32'h1111_2222, 3'b100, 7, 6, 1'b0, 32'h1111_2222, 32'h0};
    vecs[2] = '{32'h8000_0000, 1'b0, 32'h0,        -1, 0, -1, 32'h0,         3'b010, 9, 8, 1'b1, 32'h0,         32'h8000_0000};
    vecs[3] = '{32'h8000_0040, 1'b0, 32'h0,         1, 7, -1, 32'h7777_0001, 3'b010, 9, 8, 1'b0, 32'h7777_0001, 32'h8000_0000};
    vecs[4] = '{32'h0000_1000, 1'b1, 32'hFFFF_FFFF,-1, 0, -1, 32'h0,         3'b000, 1, 0, 1'b1, 32'h0,         32'h0000_1000};
    vecs[5] = '{32'h8000_0008, 1'b0, 32'h0,         1, 6, -1, 32'h3C3C_5A5A, 3'b010, 8, 7, 1'b0, 32'h3C3C_5A5A, 32'h0000_1000};
    vecs[6] = '{32'h4000_0020, 1'b0, 32'h0,         0, 3,  1, 32'h5050_6060, 3'b001, 5, 4, 1'b0, 32'h5050_6060, 32'h0000_1000};
    fresh   = '{32'h4000_0100, 1'b0, 32'h0,         0, 0, -1, 32'hCAFE_F00D, 3'b001, 2, 1, 1'b0, 32'hCAFE_F00D, 32'h0};

    // Reset values, checked before any clock edge.
    #2;
    check("reset ack", {31'h0, ack_a}, 32'h0);
    check("reset err", {31'h0, err_a}, 32'h0);
    check("reset irq", {31'h0, irq_a}, 32'h0);
    check("reset slave_stb", {29'h0, s_stb_a}, 32'h0);
    check("reset rdt", rdt_a, 32'h0);
    check("reset err_adr", err_adr_a, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 0;

    for (int i = 0; i < NV; i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i]);
    end

    adr = 32'h4000_0000; dat = 32'h0BAD_CAFE; sel = 4'h3; we = 1'b1;
    #1;
    check("passthru adr", s_adr_a, 32'h4000_0000);
    check("passthru dat", s_dat_a, 32'h0BAD_CAFE);
    check("passthru sel_we", {27'h0, s_sel_a, s_we_a}, {27'h0, 4'h3, 1'b1});

    // Acks while idle must not produce a response.
    s_ack_a = 3'b111;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack ignored", {31'h0, ack_a}, 32'h0);
    end
    @(posedge clk); #1 s_ack_a = '0;

    // Abort: strobe dropped while a slave is being waited on.
    adr = 32'hC000_0008; we = 1'b0; stb_a = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort slave_stb", {29'h0, s_stb_a}, {29'h0, 3'b100});
    @(posedge clk); #1 stb_a = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("abort no_ack", {31'h0, ack_a}, 32'h0);
      check("abort stb_dropped", {29'h0, s_stb_a}, 32'h0);
      check("abort no_irq", {31'h0, irq_a}, 32'h0);
    end
    check("abort err_adr_held", err_adr_a, 32'h0000_1000);
    @(posedge clk); #1;

    // Reset in the middle of an ACTIVE access.
    adr = 32'h4000_0000; stb_a = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid slave_stb", {29'h0, s_stb_a}, {29'h0, 3'b001});
    #2 rst = 1'b1;
    #1;
    check("rst_mid stb_dropped", {29'h0, s_stb_a}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid no_ack", {31'h0, ack_a}, 32'h0);
      check("rst_mid no_stb", {29'h0, s_stb_a}, 32'h0);
    end
    @(posedge clk); #1 stb_a = 1'b0; rst = 1'b0;
    check("rst_mid err_adr_cleared", err_adr_a, 32'h0);
    apply_vec("fresh_after_reset", fresh);

    // Two-slave instance: region 3 is unmapped.
    adr = 32'hC000_0000; stb_b = 1'b1;
    @(negedge clk);
    check("b cycle0 no_ack", {31'h0, ack_b}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b unmapped ack", {31'h0, ack_b}, 32'h1);
    check("b unmapped err", {31'h0, err_b}, 32'h1);
    check("b unmapped irq", {31'h0, irq_b}, 32'h1);
    check("b unmapped slave_stb", {30'h0, s_stb_b}, 32'h0);
    check("b unmapped rdt", rdt_b, 32'h0);
    check("b unmapped err_adr", err_adr_b, 32'hC000_0000);
    @(posedge clk); #1 stb_b = 1'b0;
    @(negedge clk);
    check("b single_ack", {31'h0, ack_b}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
